// File: rtl/bcd_serial_addsub_seq.sv
// Serial packed-BCD adder/subtractor. Processes one byte (two BCD digits) per clock,
// low byte first. Subtraction is done as a + nines'-complement(b) + 1.
module bcd_serial_addsub_seq #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  c_out,
   output logic                  err
);

   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q;
   logic [8*NBYTES-1:0] a_q;
   logic [8*NBYTES-1:0] b_q;
   logic                sub_q;
   logic [IW-1:0]       idx_q;
   logic                carry_q;

   logic [7:0]          a_byte;
   logic [7:0]          b_byte;
   logic [4:0]          lo_res;
   logic [4:0]          hi_res;
   logic [7:0]          byte_res;
   logic                byte_bad;

   // One decimal digit: returns {cout, digit}. b is nines'-complemented (4-bit wrap) in sub mode.
   function automatic logic [4:0] bcd_digit(input logic [3:0] ad, input logic [3:0] bd,
                                            input logic s, input logic cin);
      logic [3:0] bp;
      logic [4:0] sum;
      bp  = s ? (4'd9 - bd) : bd;
      sum = {1'b0, ad} + {1'b0, bp} + {4'd0, cin};
      if (sum > 5'd9) begin
         bcd_digit = {1'b1, sum[3:0] + 4'd6};
      end else begin
         bcd_digit = {1'b0, sum[3:0]};
      end
   endfunction

   // Arithmetic for the byte currently selected by idx_q.
   always_comb begin
      a_byte   = a_q[{idx_q, 3'b000} +: 8];
      b_byte   = b_q[{idx_q, 3'b000} +: 8];
      lo_res   = bcd_digit(a_byte[3:0], b_byte[3:0], sub_q, carry_q);
      hi_res   = bcd_digit(a_byte[7:4], b_byte[7:4], sub_q, lo_res[4]);
      byte_res = {hi_res[3:0], lo_res[3:0]};
      byte_bad = (a_byte[3:0] > 4'd9) || (a_byte[7:4] > 4'd9) ||
                 (b_byte[3:0] > 4'd9) || (b_byte[7:4] > 4'd9);
   end

   // Control FSM with registered outputs; reset has priority over start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         c_out   <= 1'b0;
         err     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sub_q   <= sub;
                  idx_q   <= '0;
                  carry_q <= sub;
                  err     <= 1'b0;
                  c_out   <= 1'b0;
                  result  <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               result[{idx_q, 3'b000} +: 8] <= byte_res;
               carry_q <= hi_res[4];
               err     <= err | byte_bad;
               if (idx_q == LastIdx) begin
                  // Sub mode: a final carry means no borrow.
                  c_out   <= sub_q ? ~hi_res[4] : hi_res[4];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_addsub_seq.sv
// Directed self-checking bench for bcd_serial_addsub_seq with NBYTES=4.
module tb_bcd_serial_addsub_seq;

   localparam int unsigned NBYTES = 4;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic                sub;
   logic [8*NBYTES-1:0] a;
   logic [8*NBYTES-1:0] b;
   logic                busy;
   logic                done;
   logic [8*NBYTES-1:0] result;
   logic                c_out;
   logic                err;

   int checks = 0;
   int errors = 0;

   bcd_serial_addsub_seq #(.NBYTES(NBYTES)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .c_out  (c_out),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start an operation, follow it through busy and done, and check the held result.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic [31:0] exp_res, input logic exp_c,
                         input logic exp_e);
      a = av; b = bv; sub = sv; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(NBYTES); i++) begin
         check({tag, "_busy"}, 64'(busy), 64'd1);
         check({tag, "_nodone"}, 64'(done), 64'd0);
         tick();
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy_lo"}, 64'(busy), 64'd0);
      check({tag, "_result"}, 64'(result), 64'(exp_res));
      check({tag, "_c_out"}, 64'(c_out), 64'(exp_c));
      check({tag, "_err"}, 64'(err), 64'(exp_e));
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_hold"}, 64'(result), 64'(exp_res));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_c_out", 64'(c_out), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      tick();

      run_op("ripple", 32'h00000001, 32'h00009999, 1'b0, 32'h00010000, 1'b0, 1'b0);
      run_op("carry", 32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
      run_op("sub_nb", 32'h00000100, 32'h00000001, 1'b1, 32'h00000099, 1'b0, 1'b0);
      run_op("sub_b", 32'h00000000, 32'h00000001, 1'b1, 32'h99999999, 1'b1, 1'b0);
      run_op("inval", 32'h0000000A, 32'h00000000, 1'b0, 32'h00000010, 1'b0, 1'b1);

      // Start during busy is ignored; exactly one done pulse.
      a = 32'h00000001; b = 32'h00009999; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 32'h11111111; b = 32'h22222222; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_busy", 64'(busy), 64'd1);
      tick();
      check("ign_not_yet", 64'(done), 64'd0);
      tick();
      check("ign_done", 64'(done), 64'd1);
      check("ign_result", 64'(result), 64'h00010000);
      check("ign_c_out", 64'(c_out), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("ign_single_done", 64'(done), 64'd0);
         check("ign_idle", 64'(busy), 64'd0);
      end

      // Reset during RUN aborts; a start coincident with reset is discarded.
      a = 32'h00000000; b = 32'h00000001; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("abort_partial", 64'(result), 64'h00000099);
      tick();
      check("abort_partial2", 64'(result), 64'h00009999);
      rst_n = 1'b0; start = 1'b1;
      tick();
      rst_n = 1'b1; start = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", 64'(result), 64'd0);
      check("abort_c_out", 64'(c_out), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_done", 64'(done), 64'd0);
         check("abort_no_busy", 64'(busy), 64'd0);
      end

      run_op("after", 32'h00000100, 32'h00000001, 1'b1, 32'h00000099, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
